dmem_responder: RTL and testbench

- Data-memory responder for the single-cycle core's data-memory port.
- Accepts the core's address, write data, write-enable and read-enable signals.
- Stores N-bit doublewords with per-byte write lanes.
- Returns read data after a parameterised latency, using a ready/stall handshake that the core uses to freeze PC and register writeback.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The optional statistics counters are enabled with DMEM_STATS_EN.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

  localparam int STATS_RD_W  = 32;
  localparam int STATS_MIS_W = 16;

  // Drop the byte offset, then keep only the bits that address the array.
  // Any upper address bits are discarded, so addresses wrap around.
  function automatic int unsigned word_index(input logic [63:0] addr,
                                             input int unsigned wb,
                                             input int unsigned aw);
    logic [63:0] sh;
    sh = addr >> wb;
    return 32'(sh & ((64'd1 << aw) - 64'd1));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane synchronous write and a registered read port.
// The read register updates only on a read strobe, so it holds a stable snapshot.
module dmem_array #(
  parameter int N     = 64,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [N-1:0]    wdata,
  input  logic [N/8-1:0]  wmask,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [N-1:0]    rdata
);

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < N/8; i++) begin
        if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores complete in one cycle; loads stall the core for
// READ_LATENCY cycles. Define DMEM_STATS_EN to add the rd/wr/misalign counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N            = 64,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    DM_addr,
  input  logic [N-1:0]    DM_writeData,
  input  logic [N/8-1:0]  DM_byteMask,
  input  logic            DM_writeEnable,
  input  logic            DM_readEnable,
  output logic [N-1:0]    DM_readData,
  output logic            DM_ready,
`ifdef DMEM_STATS_EN
  output logic [STATS_RD_W-1:0]  rd_count,
  output logic [STATS_RD_W-1:0]  wr_count,
  output logic [STATS_MIS_W-1:0] misalign_count,
`endif
  output logic            DM_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int WB = $clog2(N/8);

  dmem_state_t  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [WB-1:0] off_q, off_d;
  logic         rd_acc, wr_do;
  logic [AW-1:0] widx;
  logic [N-1:0] snap;

  assign widx          = AW'(word_index(64'(DM_addr), WB, AW));
  assign DM_misaligned = (DM_writeEnable | DM_readEnable) && (DM_addr[WB-1:0] != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    rd_acc   = 1'b0;
    wr_do    = 1'b0;
    DM_ready = 1'b1;
    case (state_q)
      IDLE: begin
        // A store takes priority; a simultaneous load is dropped.
        if (DM_writeEnable) begin
          wr_do = ~DM_misaligned;
        end else if (DM_readEnable) begin
          DM_ready = 1'b0;
          rd_acc   = 1'b1;
          cnt_d    = 4'(READ_LATENCY - 1);
          off_d    = DM_addr[WB-1:0];
          state_d  = (READ_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        DM_ready = 1'b0;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
    end
  end

  dmem_array #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (wr_do & ~reset),
    .waddr (widx),
    .wdata (DM_writeData),
    .wmask (DM_byteMask),
    .re    (rd_acc & ~reset),
    .raddr (widx),
    .rdata (snap)
  );

  // A misaligned load still runs the full handshake but returns zero.
  assign DM_readData = (state_q == DONE && off_q == '0) ? snap : '0;

`ifdef DMEM_STATS_EN
  logic [STATS_RD_W-1:0]  rd_count_q, rd_count_d;
  logic [STATS_RD_W-1:0]  wr_count_q, wr_count_d;
  logic [STATS_MIS_W-1:0] mis_count_q, mis_count_d;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mis_count_d = mis_count_q;
    if (rd_acc && rd_count_q != '1)                 rd_count_d  = rd_count_q + 1'b1;
    if (wr_do && |DM_byteMask && wr_count_q != '1)  wr_count_d  = wr_count_q + 1'b1;
    if (state_q == IDLE && DM_misaligned && mis_count_q != '1)
      mis_count_d = mis_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;
  assign misalign_count = mis_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a word-array model.
module tb_dmem_responder;

  localparam int N = 64;
  localparam int DEPTH = 512;
  localparam int L = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  DM_addr, DM_writeData, DM_readData;
  logic [7:0]    DM_byteMask;
  logic          DM_writeEnable, DM_readEnable, DM_ready, DM_misaligned;
`ifdef DMEM_STATS_EN
  logic [31:0]   rd_count, wr_count;
  logic [15:0]   misalign_count;
`endif

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [63:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_byteMask    (DM_byteMask),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .DM_ready       (DM_ready),
`ifdef DMEM_STATS_EN
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .misalign_count (misalign_count),
`endif
    .DM_misaligned  (DM_misaligned)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [63:0] a);
    return 32'((a / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] expect_load(input logic [63:0] a);
    if (a[2:0] != 3'd0) return 64'd0;
    return model[idx_of(a)];
  endfunction

  // Called right after a posedge (+1); leaves time at the next posedge (+1).
  task automatic do_store(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] m, input logic both);
    DM_addr = a; DM_writeData = d; DM_byteMask = m;
    DM_writeEnable = 1'b1; DM_readEnable = both;
    #1;
    chk("st_ready", 64'(DM_ready), 64'd1);
    chk("st_mis", 64'(DM_misaligned), 64'(a[2:0] != 3'd0));
    @(posedge clk); #1;
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    if (a[2:0] == 3'd0)
      for (int i = 0; i < 8; i++)
        if (m[i]) model[idx_of(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic do_load(input logic [63:0] a, input logic [63:0] exp);
    DM_addr = a; DM_writeEnable = 1'b0; DM_readEnable = 1'b1;
    DM_writeData = 64'( 0); DM_byteMask = 8'h00;
    #1;
    chk("ld_mis", 64'(DM_misaligned), 64'(a[2:0] != 3'd0));
    for (int i = 0; i < L; i++) begin
      if (i > 0) #1;
      chk("ld_stall", 64'(DM_ready), 64'd0);
      @(posedge clk); #1;
    end
    #1;
    chk("ld_done_ready", 64'(DM_ready), 64'd1);
    chk("ld_data", DM_readData, exp);
    @(posedge clk); #1;
    DM_readEnable = 1'b0;
    #1;
    chk("idle_data", DM_readData, 64'd0);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [7:0]  m;

    reset = 1'b1; DM_addr = '0; DM_writeData = '0; DM_byteMask = '0;
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 64'(DM_ready), 64'd1);
    chk("rst_data", DM_readData, 64'd0);
    chk("rst_mis", 64'(DM_misaligned), 64'd0);
`ifdef DMEM_STATS_EN
    chk("rst_rdcnt", 64'(rd_count), 64'd0);
    chk("rst_wrcnt", 64'(wr_count), 64'd0);
`endif

    // Fill every word so later loads never see uninitialized storage.
    for (int i = 0; i < DEPTH; i++)
      do_store(64'(i) * 64'd8, {$urandom, $urandom}, 8'hFF, 1'b0);

    do_store(64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0);
    do_load(64'h40, 64'hDEADBEEF_CAFEF00D);
    do_store(64'h40, 64'h11, 8'h01, 1'b0);
    do_load(64'h40, 64'hDEADBEEF_CAFEF011);

    do_store(64'h43, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    do_load(64'h40, 64'hDEADBEEF_CAFEF011);
    do_load(64'h43, 64'd0);

    do_store(64'h1000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
    do_load(64'h0, 64'h1234_5678_9ABC_DEF0);

    do_store(64'h48, 64'h0, 8'h00, 1'b0);
    do_load(64'h48, expect_load(64'h48));

    // Reset while the load is waiting must abort it cleanly.
    DM_addr = 64'h40; DM_readEnable = 1'b1;
    @(posedge clk); #1;
    #1 chk("wait_stall", 64'(DM_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; DM_readEnable = 1'b0;
    #1;
    chk("abort_ready", 64'(DM_ready), 64'd1);
    chk("abort_data", DM_readData, 64'd0);
    do_load(64'h40, 64'hDEADBEEF_CAFEF011);

    do_store(64'h8, 64'h5, 8'hFF, 1'b1);
    do_load(64'h8, 64'h5);

    for (int k = 0; k < 300; k++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a[2:0] = 3'd0;
      if ($urandom_range(0, 1) == 0) begin
        d = {$urandom, $urandom};
        m = 8'($urandom_range(0, 255));
        do_store(a, d, m, 1'($urandom_range(0, 3) == 0));
      end else begin
        do_load(a, expect_load(a));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
